// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the BRAM read arbiter.
// Holds the response FSM state encoding and the legal client-count range.
package bram_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  localparam int CLIENT_COUNT_MIN = 2;
  localparam int CLIENT_COUNT_MAX = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Searches the request vector starting one past last_grant, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [IW-1:0] cand [N];

  // cand[k] is the client examined at search position k (highest priority first).
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(last_grant) + gi + 1) % N);
    end
  endgenerate

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && request[cand[k]]) begin
        any               = 1'b1;
        index             = cand[k];
        grant[cand[k]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares one BRAM read port among CLIENT_COUNT requesters, one read outstanding.
// A new grant is issued in the same cycle the pending response is accepted.
module bram_read_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ENTRY_COUNT  = 1024,
  parameter int DATA_WIDTH   = 32,
  parameter int CLIENT_COUNT = 2,
  parameter int AW           = $clog2(ENTRY_COUNT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CLIENT_COUNT-1:0]      req_valid,
  input  logic [CLIENT_COUNT*AW-1:0]   req_address,
  output logic [CLIENT_COUNT-1:0]      req_ready,
  output logic [CLIENT_COUNT-1:0]      resp_valid,
  input  logic [CLIENT_COUNT-1:0]      resp_ready,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic                         bram_read_enable,
  output logic [AW-1:0]                bram_read_address,
  input  logic [DATA_WIDTH-1:0]        bram_read_data
);

  localparam int IW = $clog2(CLIENT_COUNT);

  generate
    if (CLIENT_COUNT < CLIENT_COUNT_MIN || CLIENT_COUNT > CLIENT_COUNT_MAX) begin : g_bad_count
      $error("bram_read_arbiter: CLIENT_COUNT out of range");
    end
  endgenerate

  arb_state_t          state_reg, state_next;
  logic [IW-1:0]       owner_reg, owner_next;
  logic [IW-1:0]       last_grant_reg, last_grant_next;
  logic [CLIENT_COUNT-1:0] grant;
  logic [IW-1:0]       grant_index;
  logic                grant_any;
  logic                accept;
  logic                free;
  logic                grant_en;

  rr_arbiter #(
    .N  (CLIENT_COUNT),
    .IW (IW)
  ) u_rr (
    .request    (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .index      (grant_index),
    .any        (grant_any)
  );

  assign accept   = (state_reg == RESP) && resp_ready[owner_reg];
  assign free     = (state_reg == IDLE) || accept;
  // Gating with reset keeps the combinational outputs quiet while reset is held.
  assign grant_en = free && grant_any && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_grant_reg <= IW'(CLIENT_COUNT - 1);
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    owner_next        = owner_reg;
    last_grant_next   = last_grant_reg;
    req_ready         = '0;
    bram_read_enable  = 1'b0;
    bram_read_address = '0;
    if (grant_en) begin
      state_next        = RESP;
      owner_next        = grant_index;
      last_grant_next   = grant_index;
      req_ready         = grant;
      bram_read_enable  = 1'b1;
      bram_read_address = req_address[grant_index*AW +: AW];
    end else if (accept) begin
      state_next = IDLE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CLIENT_COUNT; gi++) begin : g_resp
      assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == IW'(gi));
    end
  endgenerate

  // The BRAM holds its output while enable is low, so data stays stable during a stall.
  assign resp_data = bram_read_data;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: two instances (2 and 4 clients) each with a preloaded BRAM.
// A per-cycle reference model plus directed literal checks.
module tb_bram_read_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Two-client instance
  logic [1:0]  rv2, rr2, rq2, rsv2;
  logic [19:0] ra2;
  logic [31:0] rd2, bd2;
  logic        en2;
  logic [9:0]  ad2;

  // Four-client instance
  logic [3:0]  rv4, rr4, rq4, rsv4;
  logic [39:0] ra4;
  logic [31:0] rd4, bd4;
  logic        en4;
  logic [9:0]  ad4;

  bram_read_arbiter #(.ENTRY_COUNT(1024), .DATA_WIDTH(32), .CLIENT_COUNT(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_address(ra2), .req_ready(rq2),
    .resp_valid(rsv2), .resp_ready(rr2), .resp_data(rd2),
    .bram_read_enable(en2), .bram_read_address(ad2), .bram_read_data(bd2));

  bram_read_arbiter #(.ENTRY_COUNT(1024), .DATA_WIDTH(32), .CLIENT_COUNT(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(rv4), .req_address(ra4), .req_ready(rq4),
    .resp_valid(rsv4), .resp_ready(rr4), .resp_data(rd4),
    .bram_read_enable(en4), .bram_read_address(ad4), .bram_read_data(bd4));

  logic [31:0] mem2 [1024];
  logic [31:0] mem4 [1024];
  initial begin
    for (int a = 0; a < 1024; a++) begin
      mem2[a] = 32'(a) + 32'h100;
      mem4[a] = 32'(a) + 32'h100;
    end
  end
  always @(posedge clk) begin
    if (en2) bd2 <= mem2[ad2];
    if (en4) bd4 <= mem4[ad4];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one pending response at most, round-robin after last grant.
  typedef struct {
    bit          busy;
    int          owner;
    int          last;
    logic [31:0] pdata;
  } ms_t;

  ms_t m2, m4;

  function automatic ms_t reset_state(input int n);
    ms_t r;
    r.busy = 0; r.owner = 0; r.last = n - 1; r.pdata = '0;
    return r;
  endfunction

  task automatic model_check(input string tag, input int n, input ms_t s, output ms_t nx,
                             input logic [7:0] rv, input logic [7:0] rr, input logic [79:0] ra,
                             input logic [7:0] a_ready, input logic [7:0] a_respv,
                             input logic a_en, input logic [9:0] a_addr, input logic [31:0] a_data);
    logic [7:0]  e_ready, e_respv;
    logic [9:0]  e_addr;
    bit          free;
    int          g, c;
    e_ready = '0; e_respv = '0; e_addr = '0; g = -1;
    nx = s;
    if (s.busy) e_respv[s.owner] = 1'b1;
    free = !s.busy || rr[s.owner];
    if (free) begin
      for (int k = 1; k <= n; k++) begin
        c = (s.last + k) % n;
        if (g < 0 && rv[c]) g = c;
      end
    end
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      e_addr     = ra[g*10 +: 10];
      nx.busy = 1; nx.owner = g; nx.last = g; nx.pdata = 32'(e_addr) + 32'h100;
    end else if (s.busy && rr[s.owner]) begin
      nx.busy = 0;
    end
    chk({tag, "_model_req_ready"}, 64'(a_ready), 64'(e_ready));
    chk({tag, "_model_resp_valid"}, 64'(a_respv), 64'(e_respv));
    chk({tag, "_model_enable"}, 64'(a_en), 64'(g >= 0));
    if (g >= 0) chk({tag, "_model_address"}, 64'(a_addr), 64'(e_addr));
    if (s.busy) chk({tag, "_model_resp_data"}, 64'(a_data), 64'(s.pdata));
  endtask

  always @(negedge clk) begin
    ms_t n2, n4;
    if (reset) begin
      chk("rst2_outputs", {rq2, rsv2, en2, ad2}, '0);
      chk("rst4_outputs", {rq4, rsv4, en4, ad4}, '0);
      m2 = reset_state(2);
      m4 = reset_state(4);
    end else begin
      model_check("d2", 2, m2, n2, {6'b0, rv2}, {6'b0, rr2}, {60'b0, ra2},
                  {6'b0, rq2}, {6'b0, rsv2}, en2, ad2, rd2);
      model_check("d4", 4, m4, n4, {4'b0, rv4}, {4'b0, rr4}, {40'b0, ra4},
                  {4'b0, rq4}, {4'b0, rsv4}, en4, ad4, rd4);
      m2 = n2;
      m4 = n4;
    end
  end

  task automatic drive2(input logic [1:0] v, input logic [9:0] a0, input logic [9:0] a1,
                        input logic [1:0] r);
    @(posedge clk); #1;
    rv2 = v; ra2 = {a1, a0}; rr2 = r;
    @(negedge clk);
  endtask

  int cnt [4];
  int since [4];
  int maxwait;
  int g;

  initial begin
    reset = 1'b1;
    rv2 = '0; ra2 = '0; rr2 = '0;
    rv4 = '0; ra4 = '0; rr4 = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {rq2, rsv2, en2, ad2}, '0);
    @(posedge clk); #1 reset = 1'b0;

    // Single read, 1-cycle latency
    drive2(2'b01, 10'd5, 10'd0, 2'b11);
    chk("single_ready", 64'(rq2), 64'h1);
    chk("single_enable", 64'(en2), 64'h1);
    chk("single_address", 64'(ad2), 64'd5);
    drive2(2'b00, 10'd5, 10'd0, 2'b11);
    chk("single_resp_valid", 64'(rsv2), 64'h1);
    chk("single_resp_data", 64'(rd2), 64'h105);
    drive2(2'b00, 10'd0, 10'd0, 2'b11);
    chk("single_idle_after", 64'(rsv2), 64'h0);

    // Backpressure on client 1; client 0 asks meanwhile, non-owner ready is ignored
    drive2(2'b10, 10'd0, 10'd7, 2'b00);
    chk("bp_grant", {rq2, en2, ad2}, {2'b10, 1'b1, 10'd7});
    for (int s = 0; s < 3; s++) begin
      drive2(2'b01, 10'd3, 10'd7, 2'b01);
      chk("bp_stall_resp", {rsv2, rd2}, {2'b10, 32'h107});
      chk("bp_stall_quiet", {rq2, en2}, 3'b000);
    end
    drive2(2'b01, 10'd3, 10'd7, 2'b10);
    chk("bp_accept_resp", {rsv2, rd2}, {2'b10, 32'h107});
    chk("bp_accept_grant", {rq2, en2, ad2}, {2'b01, 1'b1, 10'd3});

    // Back-to-back: accept 0x103 while client 1 requests addr 9
    drive2(2'b10, 10'd3, 10'd9, 2'b01);
    chk("b2b_resp0", {rsv2, rd2}, {2'b01, 32'h103});
    chk("b2b_grant1", {rq2, en2, ad2}, {2'b10, 1'b1, 10'd9});
    drive2(2'b00, 10'd0, 10'd9, 2'b00);
    chk("b2b_resp1", {rsv2, rd2}, {2'b10, 32'h109});
    drive2(2'b01, 10'd4, 10'd9, 2'b10);
    chk("b2b_regrant0", 64'(rq2), 64'h1);
    drive2(2'b00, 10'd4, 10'd9, 2'b00);
    chk("pre_reset_resp0", {rsv2, rd2}, {2'b01, 32'h104});

    // Reset while a response is pending
    @(posedge clk); #1;
    reset = 1'b1; rv2 = 2'b11; ra2 = {10'd2, 10'd1}; rr2 = 2'b11;
    @(negedge clk);
    chk("midrst_outputs", {rq2, rsv2, en2}, '0);
    @(posedge clk); #1 reset = 1'b0;

    // Contention after reset: 0,1,0,1 with alternating data
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_grant", 64'(rq2), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k == 0) chk("cont_no_stale_resp", 64'(rsv2), 64'h0);
      else begin
        chk("cont_resp_valid", 64'(rsv2), (k % 2 == 1) ? 64'h1 : 64'h2);
        chk("cont_resp_data", 64'(rd2), (k % 2 == 1) ? 64'h101 : 64'h102);
      end
      @(posedge clk); #1;
    end
    rv2 = '0;

    // Fairness on four clients
    rv4 = 4'hF; ra4 = {10'd13, 10'd12, 10'd11, 10'd10}; rr4 = 4'hF;
    for (int c = 0; c < 4; c++) begin cnt[c] = 0; since[c] = 0; end
    maxwait = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      g = -1;
      for (int c = 0; c < 4; c++) if (rq4[c]) g = c;
      for (int c = 0; c < 4; c++) begin
        if (c == g) begin
          if (since[c] > maxwait) maxwait = since[c];
          since[c] = 0;
          cnt[c]++;
        end else begin
          since[c]++;
        end
      end
    end
    @(posedge clk); #1 rv4 = '0;
    for (int c = 0; c < 4; c++) chk($sformatf("fair_count_%0d", c), 64'(cnt[c]), 64'd25);
    chk("fair_max_wait", 64'(maxwait), 64'd3);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_read_arbiter.md
BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 SHALL have parameter ENTRY_COUNT, default 1024, meaning BRAM depth; address width AW = $clog2(ENTRY_COUNT).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning BRAM word width.
REQ-003 SHALL have parameter CLIENT_COUNT, default 2, meaning number of read requesters; legal range 2..8.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  CLIENT_COUNT  per-client read request.
REQ-007 req_address  input  CLIENT_COUNT*AW  per-client address, client i at bits [i*AW +: AW].
REQ-008 req_ready  output  CLIENT_COUNT  per-client request accepted this cycle.
REQ-009 resp_valid  output  CLIENT_COUNT  per-client response data valid.
REQ-010 resp_ready  input  CLIENT_COUNT  per-client response accepted.
REQ-011 resp_data  output  DATA_WIDTH  shared response data, meaningful only where resp_valid is high.
REQ-012 bram_read_enable  output  1  drives the BRAM read enable.
REQ-013 bram_read_address  output  AW  drives the BRAM read address.
REQ-014 bram_read_data  input  DATA_WIDTH  BRAM registered read data, valid 1 cycle after enable.

Function
REQ-015 SHALL keep at most one read outstanding; states IDLE (no response pending) and RESP (response pending for client owner).
REQ-016 SHALL grant exactly one client per cycle when free = (state==IDLE) or (resp_valid[owner] and resp_ready[owner]), and at least one req_valid is high.
REQ-017 SHALL select the grant by round-robin: search starts at last_grant+1 modulo CLIENT_COUNT.
REQ-018 req_ready SHALL be one-hot grant, combinational from req_valid and state; all zero when not free.
REQ-019 On grant to client i, same cycle: bram_read_enable=1, bram_read_address=address of client i; next cycle: state=RESP, owner=i, last_grant=i.
REQ-020 bram_read_enable SHALL be 0 whenever no grant occurs, so BRAM output holds during response stall.
REQ-021 In RESP, resp_valid SHALL be one-hot at owner; resp_data SHALL equal bram_read_data.
REQ-022 resp_valid[owner] SHALL stay high with resp_data stable until resp_ready[owner]; resp_ready of non-owners SHALL be ignored.
REQ-023 Response accept with no new grant SHALL return to IDLE next cycle; accept with new grant SHALL stay in RESP with the new owner (back-to-back, one read per cycle).
REQ-024 Request-to-response latency SHALL be exactly 1 cycle when the arbiter is free.
REQ-025 A client with req_valid high and no req_ready SHALL be granted within CLIENT_COUNT grants (no starvation).

Reset
REQ-026 During reset: state=IDLE, owner=0, last_grant=CLIENT_COUNT-1 (client 0 has first priority); req_ready, resp_valid, bram_read_enable all 0; bram_read_address 0.
REQ-027 Reset asserted with a response pending SHALL drop it; no response SHALL appear after release.

Structure
REQ-028 Package bram_arbiter_pkg SHALL hold the state enum (IDLE, RESP) and the CLIENT_COUNT legal-range constants.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs request vector and last_grant; output one-hot grant and encoded index); purely combinational.
REQ-030 The BRAM SHALL be instantiated outside this block; the write port is not arbitered here.

Verification (bench pairs the block with a 1024x32 BRAM preloaded mem[a]=a+0x100)
REQ-031 Single: client 0 req addr 5 in cycle 0 -> req_ready[0]=1 cycle 0; resp_valid[0]=1, resp_data=0x105 cycle 1.
REQ-032 Contention: both clients valid continuously, resp_ready=1, addrs 1/2 -> grants alternate 0,1,0,1; data 0x101,0x102 alternating, one per cycle.
REQ-033 Backpressure: client 1 reads addr 7, resp_ready[1] low 3 cycles -> resp_data=0x107 held 4 cycles; bram_read_enable=0 and req_ready=0 throughout the stall.
REQ-034 Back-to-back accept: client 0 accepts 0x103 while client 1 requests addr 9 -> next cycle resp_valid[1]=1, data 0x109, state never IDLE.
REQ-035 Reset mid-operation: reset asserted while resp_valid[0]=1 -> outputs 0 immediately; after release, first grant to client 0 when both request.
REQ-036 Fairness: CLIENT_COUNT=4, all valid 100 cycles, resp_ready=1 -> each client granted 25 times, max wait 3 grants.
